// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared definitions for the video RAM arbiter.
// Contents: grid geometry defaults (16 x 12 = 192 cells), default widths and
// depths, the arbiter state encoding, and the color used to blank the screen.
package vram_arbiter_pkg;

  localparam int GRID_COLS  = 16;
  localparam int GRID_ROWS  = 12;
  localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

  localparam int DEF_CELL_AW      = 8;
  localparam int DEF_COLOR_W      = 3;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] CLEAR_COLOR = COLOR_BLACK;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // Linear cell index for a (row, col) position on the default grid.
  function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vram_arbiter_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO buffering CPU cell writes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (flushes contents)
//   push, wdata     - enqueue one entry (ignored when full)
//   pop             - dequeue head entry (ignored when empty)
//   rdata           - head entry, valid whenever empty is low
//   full, empty     - occupancy flags, derived from the registered pointers
module vram_wr_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port video RAM between buffered CPU writes,
// display scanout reads and a full-screen clear sequencer.
// Ports:
//   Clock, Reset                     - clock, synchronous active-high reset
//   iWrReq/iWrAddr/iWrColor, oWrBusy - CPU write path (stall while oWrBusy)
//   iRdReq/iRdAddr, oRdGrant         - scanout read request, same-cycle grant
//   oRdValid/oRdColor                - read data, one cycle after the grant
//   iClear, oClearBusy               - start / progress of the screen clear
//   oRamAddr/oRamWe/oRamWData        - RAM command for this cycle
//   iRamRData                        - RAM read data, 1-cycle latency
//   oErrCount                        - dropped out-of-range writes
// Optional feature: define VRAM_ARB_BOUNDS_CHECK_EN to drop out-of-range
// writes (counted in oErrCount) and answer out-of-range reads with color 0.
import vram_arbiter_pkg::*;

module vram_arbiter #(
  parameter int CELL_AW      = DEF_CELL_AW,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int NUM_CELLS    = GRID_CELLS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iWrReq,
  input  logic [CELL_AW-1:0] iWrAddr,
  input  logic [COLOR_W-1:0] iWrColor,
  output logic               oWrBusy,
  input  logic               iRdReq,
  input  logic [CELL_AW-1:0] iRdAddr,
  output logic               oRdGrant,
  output logic               oRdValid,
  output logic [COLOR_W-1:0] oRdColor,
  input  logic               iClear,
  output logic               oClearBusy,
  output logic [CELL_AW-1:0] oRamAddr,
  output logic               oRamWe,
  output logic [COLOR_W-1:0] oRamWData,
  input  logic [COLOR_W-1:0] iRamRData,
  output logic [7:0]         oErrCount
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int FW = CELL_AW + COLOR_W;
  localparam logic [SW-1:0]      STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CELL_AW-1:0] LAST_CELL  = CELL_AW'(NUM_CELLS - 1);

  arb_state_t         state;
  logic [CELL_AW-1:0] clr_ptr;
  logic [SW-1:0]      starve;
  logic               rd_valid;
  logic               rd_zero;
  logic               rd_grant;
  logic               clr_grant;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_head;
  logic               rd_oob;
  logic               wr_oob;

`ifdef VRAM_ARB_BOUNDS_CHECK_EN
  logic [7:0] err_count;
  assign rd_oob    = ({1'b0, iRdAddr} >= (CELL_AW+1)'(NUM_CELLS));
  assign wr_oob    = ({1'b0, iWrAddr} >= (CELL_AW+1)'(NUM_CELLS));
  assign oErrCount = err_count;

  // Saturating count of write requests dropped for an out-of-range address.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_count <= 8'd0;
    end else if (iWrReq && !fifo_full && wr_oob && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`else
  assign rd_oob    = 1'b0;
  assign wr_oob    = 1'b0;
  assign oErrCount = 8'd0;
`endif

  vram_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .wdata ({iWrAddr, iWrColor}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign oWrBusy    = fifo_full;
  assign oRdGrant   = rd_grant;
  assign oRdValid   = rd_valid;
  assign oClearBusy = (state == ST_CLEAR);
  // Out-of-range reads return black instead of whatever the RAM aliases to.
  assign oRdColor   = (rd_valid && !rd_zero) ? iRamRData : COLOR_W'(0);

  // Fixed-priority grant: read (unless starving writes), clear, FIFO drain, idle.
  always_comb begin
    rd_grant  = !Reset && iRdReq && (starve < STARVE_MAX);
    clr_grant = !Reset && !rd_grant && (state == ST_CLEAR);
    pop       = !Reset && !rd_grant && (state == ST_ARB) && !fifo_empty;
    push      = !Reset && iWrReq && !fifo_full && !wr_oob;
    oRamAddr  = '0;
    oRamWe    = 1'b0;
    oRamWData = '0;
    if (rd_grant) begin
      if (!rd_oob) begin
        oRamAddr = iRdAddr;
      end else begin
        oRamAddr = '0;
      end
    end else if (clr_grant) begin
      oRamAddr  = clr_ptr;
      oRamWe    = 1'b1;
      oRamWData = COLOR_W'(CLEAR_COLOR);
    end else if (pop) begin
      oRamAddr  = fifo_head[FW-1:COLOR_W];
      oRamWe    = 1'b1;
      oRamWData = fifo_head[COLOR_W-1:0];
    end else begin
      oRamWe    = 1'b0;
    end
  end

  // Clear FSM, starve counter and read-return pipeline.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_ARB;
      clr_ptr  <= '0;
      starve   <= '0;
      rd_valid <= 1'b0;
      rd_zero  <= 1'b0;
    end else begin
      rd_valid <= rd_grant;
      rd_zero  <= rd_oob;

      // Any write resets the budget; reads only spend it while a write waits.
      if (clr_grant || pop) begin
        starve <= '0;
      end else if ((state == ST_ARB) && fifo_empty) begin
        starve <= '0;
      end else if (rd_grant && (starve != STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end else begin
        starve <= starve;
      end

      case (state)
        ST_ARB: begin
          if (iClear) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end else begin
            state   <= ST_ARB;
          end
        end
        ST_CLEAR: begin
          if (clr_grant && (clr_ptr == LAST_CELL)) begin
            state   <= ST_ARB;
            clr_ptr <= '0;
          end else if (clr_grant) begin
            clr_ptr <= clr_ptr + CELL_AW'(1);
          end else begin
            clr_ptr <= clr_ptr;
          end
        end
        default: begin
          state   <= ST_ARB;
          clr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter.
// A behavioural RAM sits on the RAM port. A directed vector table covers the
// basic write/read path; hand sequences cover FIFO fill, starvation, clear and
// reset-mid-clear; a randomized phase is checked against a queue-based model.
module tb_vram_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iWrReq, iRdReq, iClear;
  logic [7:0] iWrAddr, iRdAddr;
  logic [2:0] iWrColor;
  logic       oWrBusy, oRdGrant, oRdValid, oClearBusy, oRamWe;
  logic [2:0] oRdColor, oRamWData, iRamRData;
  logic [7:0] oRamAddr, oErrCount;

  int nvec = 0;
  int nmis = 0;

  always #5 Clock = ~Clock;

  vram_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrColor(iWrColor), .oWrBusy(oWrBusy),
    .iRdReq(iRdReq), .iRdAddr(iRdAddr), .oRdGrant(oRdGrant),
    .oRdValid(oRdValid), .oRdColor(oRdColor),
    .iClear(iClear), .oClearBusy(oClearBusy),
    .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData),
    .iRamRData(iRamRData), .oErrCount(oErrCount)
  );

  // Behavioural synchronous RAM, preloaded with a nonzero pattern.
  logic [2:0] ram [256];
  logic       ram_fill;
  always @(posedge Clock) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 3'(i);
    end else if (oRamWe) begin
      ram[oRamAddr] <= oRamWData;
    end
    iRamRData <= ram[oRamAddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in;
    iWrReq = 1'b0; iWrAddr = 8'd0; iWrColor = 3'd0;
    iRdReq = 1'b0; iRdAddr = 8'd0; iClear = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge Clock); #1;
  endtask

  task automatic do_reset;
    idle_in();
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic       wr; logic [7:0] waddr; logic [2:0] wcol;
    logic       rd; logic [7:0] raddr;
    logic       e_grant, e_we; logic [7:0] e_addr; logic [2:0] e_wdata;
    logic       e_busy, e_rvalid; logic [2:0] e_rcol;
  } vec_t;
  vec_t tbl [9];

  // Reference model state for the randomized phase.
  typedef struct packed { logic [7:0] a; logic [2:0] c; } wr_t;
  wr_t        mq[$];
  int         m_starve, m_cptr;
  bit         m_clear, m_pv;
  logic [2:0] m_pc;
  logic [2:0] mm [256];

  int         den[$];
  logic [7:0] seen[$];

  initial begin
    logic [31:0] act, exp;
    int accepted, widx, nbusy;
    bit seq_ok, post_seen, busy_seen, eg, ewe;
    logic [7:0] eaddr;
    logic [2:0] ewd;

    ram_fill = 1'b1;
    do_reset();
    ram_fill = 1'b0;

    // Reset state with idle inputs.
    @(negedge Clock);
    chk("reset_outputs", {oWrBusy, oRdValid, oRdColor, oClearBusy, oRamWe, oRamAddr, oRamWData, oRdGrant},
        32'd0);
    chk("reset_errcount", oErrCount, 8'd0);
    next_cycle();

    // Directed vectors: write 37 then read it back; reads outrank queued writes.
    tbl[0] = '{1'b1, 8'd37, 3'd5, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  3'd0, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 8'd0,  3'd0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd37, 3'd5, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b0, 8'd0,  3'd0, 1'b1, 8'd37, 1'b1, 1'b0, 8'd37, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 8'd0,  3'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  3'd0, 1'b0, 1'b1, 3'd5};
    tbl[4] = '{1'b1, 8'd10, 3'd1, 1'b1, 8'd3,  1'b1, 1'b0, 8'd3,  3'd0, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 8'd11, 3'd2, 1'b1, 8'd3,  1'b1, 1'b0, 8'd3,  3'd0, 1'b0, 1'b1, 3'd3};
    tbl[6] = '{1'b0, 8'd0,  3'd0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd10, 3'd1, 1'b0, 1'b1, 3'd3};
    tbl[7] = '{1'b0, 8'd0,  3'd0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd11, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[8] = '{1'b0, 8'd0,  3'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  3'd0, 1'b0, 1'b0, 3'd0};
    for (int v = 0; v < 9; v++) begin
      iWrReq = tbl[v].wr; iWrAddr = tbl[v].waddr; iWrColor = tbl[v].wcol;
      iRdReq = tbl[v].rd; iRdAddr = tbl[v].raddr;
      @(negedge Clock);
      // Address only matters when a RAM op is issued, data only on writes.
      act = {12'd0, oRdGrant, oRamWe, (oRdGrant || oRamWe) ? oRamAddr : 8'd0,
             oRamWe ? oRamWData : 3'd0, oWrBusy, oRdValid, oRdValid ? oRdColor : 3'd0};
      exp = {12'd0, tbl[v].e_grant, tbl[v].e_we, tbl[v].e_addr, tbl[v].e_wdata,
             tbl[v].e_busy, tbl[v].e_rvalid, tbl[v].e_rcol};
      chk($sformatf("table_vec%0d", v), act, exp);
      next_cycle();
    end

    // Six back-to-back pushes with no reads: never busy, RAM sees push order.
    do_reset();
    busy_seen = 1'b0;
    seen.delete();
    for (int c = 0; c < 12; c++) begin
      iWrReq = (c < 6); iWrAddr = 8'(70 + c); iWrColor = 3'(c);
      @(negedge Clock);
      if (oWrBusy) busy_seen = 1'b1;
      if (oRamWe) seen.push_back(oRamAddr);
      next_cycle();
    end
    chk("stream_busy", busy_seen, 1'b0);
    chk("stream_count", seen.size(), 6);
    for (int k = 0; k < 6 && k < seen.size(); k++) chk("stream_order", seen[k], 8'(70 + k));

    // Continuous reads with 5 pushes: busy after 4, one denied read every 9 cycles.
    do_reset();
    accepted = 0;
    den.delete();
    iRdReq = 1'b1; iRdAddr = 8'd0;
    for (int c = 0; c < 60; c++) begin
      iWrReq = (accepted < 5); iWrAddr = 8'(60 + accepted); iWrColor = 3'(accepted);
      @(negedge Clock);
      if (c == 3) chk("starve_busy_c3", oWrBusy, 1'b0);
      if (c == 4) chk("starve_busy_c4", oWrBusy, 1'b1);
      if (!oRdGrant) den.push_back(c);
      if (iWrReq && !oWrBusy) accepted++;
      next_cycle();
    end
    chk("starve_accepted", accepted, 5);
    chk("starve_denials", den.size(), 5);
    for (int k = 0; k < 5 && k < den.size(); k++) chk("starve_denial_cycle", den[k], 9 * (k + 1));

    // Full clear with no reads, plus a write to cell 5 pushed mid-clear.
    do_reset();
    iClear = 1'b1;
    @(negedge Clock);
    chk("clear_busy_pulse_cycle", oClearBusy, 1'b0);
    next_cycle();
    iClear = 1'b0;
    widx = 0; nbusy = 0; seq_ok = 1'b1; post_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      iWrReq = (c == 100); iWrAddr = 8'd5; iWrColor = 3'd6;
      @(negedge Clock);
      if (oClearBusy) nbusy++;
      if (oRamWe && oClearBusy) begin
        if (oRamAddr != 8'(widx) || oRamWData != 3'd0) seq_ok = 1'b0;
        widx++;
      end else if (oClearBusy) begin
        seq_ok = 1'b0;
      end else if (oRamWe && oRamAddr == 8'd5 && oRamWData == 3'd6) begin
        post_seen = 1'b1;
      end
      next_cycle();
    end
    chk("clear_sequence", seq_ok, 1'b1);
    chk("clear_writes", widx, 192);
    chk("clear_busy_cycles", nbusy, 192);
    chk("clear_post_write", post_seen, 1'b1);
    chk("clear_ram_100", ram[100], 3'd0);
    chk("clear_ram_191", ram[191], 3'd0);
    chk("clear_ram_192_kept", ram[192], 3'd0 + 3'(192));
    iRdReq = 1'b1; iRdAddr = 8'd5;
    next_cycle();
    idle_in();
    @(negedge Clock);
    chk("clear_readback5", {oRdValid, oRdColor}, {1'b1, 3'd6});
    next_cycle();

    // Reset in the middle of a clear with two writes queued.
    do_reset();
    iClear = 1'b1;
    next_cycle();
    iClear = 1'b0;
    for (int c = 0; c < 5; c++) next_cycle();
    iWrReq = 1'b1; iWrAddr = 8'd20; iWrColor = 3'd7;
    next_cycle();
    iWrAddr = 8'd21;
    next_cycle();
    iWrReq = 1'b0;
    iRdReq = 1'b1; iRdAddr = 8'd1;
    next_cycle();
    Reset = 1'b1; iRdReq = 1'b0;
    next_cycle();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_mid_clear_state", {oClearBusy, oWrBusy, oRdValid}, 3'b000);
    seq_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (oRamWe) seq_ok = 1'b0;
      next_cycle();
    end
    chk("rst_mid_clear_no_writes", seq_ok, 1'b1);

    // Randomized traffic against the queue-based reference model.
    do_reset();
    mq.delete();
    m_starve = 0; m_clear = 1'b0; m_cptr = 0; m_pv = 1'b0; m_pc = 3'd0;
    for (int i = 0; i < 256; i++) mm[i] = ram[i];
    for (int cyc = 0; cyc < 2500; cyc++) begin
      iRdReq   = ($urandom_range(0, 9) < 6);
      iRdAddr  = 8'($urandom_range(0, 191));
      iWrReq   = ($urandom_range(0, 9) < 5);
      iWrAddr  = 8'($urandom_range(0, 191));
      iWrColor = 3'($urandom_range(0, 7));
      iClear   = ($urandom_range(0, 299) == 0);
      @(negedge Clock);
      chk("rnd_wrbusy", oWrBusy, (mq.size() == 4));
      chk("rnd_clearbusy", oClearBusy, m_clear);
      chk("rnd_rdvalid", oRdValid, m_pv);
      if (m_pv) chk("rnd_rdcolor", oRdColor, m_pc);
      eg = iRdReq && (m_starve < 8);
      ewe = 1'b0; eaddr = 8'd0; ewd = 3'd0;
      if (eg) begin
        eaddr = iRdAddr;
      end else if (m_clear) begin
        ewe = 1'b1; eaddr = 8'(m_cptr); ewd = 3'd0;
      end else if (mq.size() > 0) begin
        ewe = 1'b1; eaddr = mq[0].a; ewd = mq[0].c;
      end
      chk("rnd_grant", oRdGrant, eg);
      chk("rnd_we", oRamWe, ewe);
      if (eg || ewe) chk("rnd_addr", oRamAddr, eaddr);
      if (ewe) chk("rnd_wdata", oRamWData, ewd);
      // Advance the model by one clock.
      m_pv = eg;
      m_pc = mm[iRdAddr];
      if (ewe) mm[eaddr] = ewd;
      if (ewe) m_starve = 0;
      else if (!m_clear && mq.size() == 0) m_starve = 0;
      else if (eg && m_starve < 8) m_starve++;
      if (ewe && !m_clear) void'(mq.pop_front());
      if (iWrReq && busy_before(mq.size(), ewe, m_clear)) mq.push_back('{iWrAddr, iWrColor});
      if (m_clear && ewe) begin
        if (m_cptr == 191) m_clear = 1'b0;
        else m_cptr++;
      end else if (!m_clear && iClear) begin
        m_clear = 1'b1; m_cptr = 0;
      end
      next_cycle();
    end
    idle_in();

`ifdef VRAM_ARB_BOUNDS_CHECK_EN
    // Out-of-range write is dropped and counted; out-of-range read returns black.
    do_reset();
    iWrReq = 1'b1; iWrAddr = 8'd200; iWrColor = 3'd7;
    next_cycle();
    iWrReq = 1'b0;
    seq_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      if (oRamWe) seq_ok = 1'b0;
      next_cycle();
    end
    chk("oob_write_dropped", seq_ok, 1'b1);
    chk("oob_errcount", oErrCount, 8'd1);
    iRdReq = 1'b1; iRdAddr = 8'd250;
    @(negedge Clock);
    chk("oob_read_grant", oRdGrant, 1'b1);
    next_cycle();
    idle_in();
    @(negedge Clock);
    chk("oob_read_color", {oRdValid, oRdColor}, {1'b1, 3'd0});
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // The model accepts a push whenever its queue was not full at the start of the cycle.
  function automatic bit busy_before(input int size_after_pop, input bit wrote, input bit clearing);
    int size_before;
    size_before = (wrote && !clearing) ? size_after_pop + 1 : size_after_pop;
    return (size_before < 4);
  endfunction

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single-port video RAM between the CPU write path (VGA instruction: cell index + color) and the display scanout read path. CPU writes are buffered in a small FIFO so the CPU stalls only when the buffer is full. Scanout reads have priority, bounded by a starvation limit. A built-in clear sequencer blanks the whole 16×12 cell grid on command.

## Interface
- `CELL_AW`, 8, cell address width (index = row*16 + col)
- `COLOR_W`, 3, color width {R,G,B}
- `NUM_CELLS`, 192, number of valid cells (16×12)
- `FIFO_DEPTH`, 4, write buffer entries (power of two)
- `STARVE_LIMIT`, 8, consecutive read grants allowed while the FIFO is non-empty
- `Clock` in 1, system clock
- `Reset` in 1, synchronous, active-high
- `iWrReq` in 1, CPU write request
- `iWrAddr` in CELL_AW, cell index
- `iWrColor` in COLOR_W, write data
- `oWrBusy` out 1, FIFO full; CPU holds request and stalls
- `iRdReq` in 1, scanout read request
- `iRdAddr` in CELL_AW, cell index
- `oRdGrant` out 1, combinational; read issued this cycle
- `oRdValid` out 1, read data valid
- `oRdColor` out COLOR_W, read data
- `iClear` in 1, single-cycle pulse; start screen clear
- `oClearBusy` out 1, clear in progress
- `oRamAddr` out CELL_AW, RAM address
- `oRamWe` out 1, RAM write enable
- `oRamWData` out COLOR_W, RAM write data
- `iRamRData` in COLOR_W, RAM read data, synchronous, 1-cycle latency
- `oErrCount` out 8, dropped out-of-range writes (only under macro)

## Operation
- States: `ARB`, `CLEAR`. Reset → `ARB`.
- Exactly one RAM operation per cycle. Grant priority, highest first:
  1. Read, if `iRdReq` and starve counter < STARVE_LIMIT.
  2. Clear write (in `CLEAR` only).
  3. FIFO pop write (in `ARB` only).
  4. Idle (`oRamWe`=0).
- Starve counter:
  - Increments when a read is granted while the FIFO is non-empty (or state is `CLEAR`).
  - Clears on any write grant, or when the FIFO is empty in `ARB`.
  - Saturates at STARVE_LIMIT. At the limit, a pending read is denied (`oRdGrant`=0); the requester re-presents it next cycle.
- FIFO push: `iWrReq` && !`oWrBusy`. A push while full is ignored; the CPU must hold the request.
  - Push and pop in the same cycle are both legal.
  - Entry order is preserved.
- `iClear` in `ARB`:
  - Enter `CLEAR` with clear pointer = 0.
  - Each granted clear write stores color 0 at the pointer, then increments it.
  - After writing NUM_CELLS-1, return to `ARB`.
- During `CLEAR`:
  - FIFO still accepts pushes but is not drained.
  - Pending writes land after the clear completes, so post-clear CPU writes survive.
  - `iClear` while in `CLEAR` is ignored.
- No read-after-write forwarding. A read of a cell still queued in the FIFO returns the old RAM content.
- Width rules: pointer and counters wrap only as stated; FIFO pointers are log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - outputs: `oWrBusy`=0, `oRdValid`=0, `oRdColor`=0, `oClearBusy`=0, `oRamWe`=0, `oRamAddr`=0, `oRamWData`=0, `oErrCount`=0
  - internal: FIFO empty, starve counter 0
- Read latency: grant in cycle N → `oRdValid`=1 and `oRdColor`=`iRamRData` in cycle N+1.
- Write latency: push in cycle N → earliest RAM write in cycle N+1.
- `oWrBusy` is registered. It reflects FIFO full after that cycle's push/pop.
- `oClearBusy`:
  - Rises the cycle after `iClear`.
  - Falls the cycle after the final clear write.
  - Full clear with no reads takes NUM_CELLS cycles.
- Reset mid-clear or mid-drain: immediately `ARB`, FIFO flushed, queued writes lost, `oRdValid`=0 next cycle.

## Configuration
- `VRAM_ARB_BOUNDS_CHECK_EN` defined:
  - Pushes with `iWrAddr` ≥ NUM_CELLS are discarded, not queued.
  - `oErrCount` increments, saturating at 255.
  - Reads at out-of-range addresses return color 0 with normal timing, without a RAM access; the cycle counts as a read grant.
- Undefined:
  - All addresses pass through unchanged (RAM aliasing is the caller's problem).
  - `oErrCount` is tied to 0.

## Structure
- Shared package/definitions include:
  - state encodings `ST_ARB`, `ST_CLEAR`
  - `CLEAR_COLOR` (= COLOR_BLACK)
  - default grid constants (16, 12, 192)
- One sub-module: `vram_wr_fifo` — synchronous FIFO with push/pop/full/empty, parameterised by width (CELL_AW+COLOR_W) and depth.
- Arbitration, starve counter and clear FSM stay in the top module.

## Test plan
- Write addr 37 color 3'b101; 2 cycles later read addr 37 → `oRdValid` with `oRdColor`=3'b101, one cycle after grant.
- Hold `iWrReq` for 6 cycles with no reads → `oWrBusy` never asserts; RAM sees the writes in push order.
- Read continuously, push 5 writes → `oWrBusy` after 4 pushes. Reads are denied once every 9 cycles (STARVE_LIMIT=8) until the FIFO drains.
- `iClear` with no reads → 192 consecutive writes of 0 to addresses 0..191; `oClearBusy` high exactly 192 cycles. A write pushed mid-clear to addr 5 lands after the clear; reading addr 5 returns it.
- Assert `Reset` mid-clear with 2 queued writes → next cycle `oClearBusy`=0, `oWrBusy`=0, no further RAM writes.
- With `VRAM_ARB_BOUNDS_CHECK_EN`: write addr 200 → no RAM write, `oErrCount`=1. Read addr 250 → `oRdColor`=0.
